// File: rtl/arm_trace_pkg.sv
// Shared types and defaults for the ARM trace capture unit.
// ARM_TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to each captured entry.
package arm_trace_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_DEPTH  = 16;
   localparam int unsigned STAMP_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      POST = 2'd2,
      DONE = 2'd3
   } trace_state_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] instr;
      logic [DEF_DATA_W-1:0] result;
`ifdef ARM_TRACE_TIMESTAMP_EN
      logic [STAMP_W-1:0]    stamp;
`endif
   } trace_entry_t;

endpackage

// File: rtl/arm_trace_ram.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; only the control logic above it is.
module arm_trace_ram
   import arm_trace_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned WIDTH = 2 * DEF_DATA_W,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/arm_trace_capture.sv
// Trace capture unit: circular Instr/Result history frozen by a masked trigger, read out oldest first.
// Define ARM_TRACE_TIMESTAMP_EN to store a free-running cycle stamp per entry and expose RdStamp.
module arm_trace_capture
   import arm_trace_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned PTR_W     = $clog2(DEPTH),
   parameter int unsigned POST_TRIG = 4
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic [DATA_W-1:0] Instr,
   input  logic [DATA_W-1:0] Result,
   input  logic              CapValid,
   input  logic              Arm,
   input  logic [DATA_W-1:0] TrigPat,
   input  logic [DATA_W-1:0] TrigMask,
   output logic              Triggered,
   output logic              Done,
   input  logic              RdReady,
   output logic              RdValid,
   output logic [DATA_W-1:0] RdInstr,
   output logic [DATA_W-1:0] RdResult,
   output logic              RdLast,
   output logic [PTR_W:0]    Count
`ifdef ARM_TRACE_TIMESTAMP_EN
   ,
   output logic [STAMP_W-1:0] RdStamp
`endif
);

   localparam logic [PTR_W:0]   FULL      = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
   localparam logic [PTR_W-1:0] TWO_PTR   = PTR_W'(2);
   localparam logic [PTR_W-1:0] POST_LOAD = PTR_W'(POST_TRIG);

   typedef struct packed {
      logic [DATA_W-1:0]  instr;
      logic [DATA_W-1:0]  result;
`ifdef ARM_TRACE_TIMESTAMP_EN
      logic [STAMP_W-1:0] stamp;
`endif
   } entry_t;

   localparam int unsigned ENTRY_W = $bits(entry_t);

   trace_state_t   state;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] post_cnt;
   logic [PTR_W:0]   count;

   logic             cap_wr;
   logic             trig_hit;
   logic             enter_done;
   logic [PTR_W-1:0] waddr;
   logic [PTR_W-1:0] wptr_nxt;
   logic [PTR_W:0]   count_base;
   logic [PTR_W:0]   count_nxt;
   entry_t           wr_entry;
   entry_t           rd_entry;

`ifdef ARM_TRACE_TIMESTAMP_EN
   logic [STAMP_W-1:0] stamp_cnt;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         stamp_cnt <= '0;
      end else begin
         stamp_cnt <= stamp_cnt + 1'b1;
      end
   end
`endif

   // An Arm restart reuses the same write path: a valid entry that cycle lands at slot 0.
   always_comb begin
      cap_wr     = CapValid && ((state == PRE) || (state == POST));
      trig_hit   = CapValid && (state == PRE) && !Arm &&
                   (((Instr ^ TrigPat) & TrigMask) == '0);
      waddr      = Arm ? '0 : wptr;
      wptr_nxt   = waddr + ONE_PTR;
      count_base = Arm ? '0 : count;
      count_nxt  = (count_base == FULL) ? FULL : count_base + ONE_CNT;
      enter_done = !Arm &&
                   ((trig_hit && (POST_TRIG == 0)) ||
                    ((state == POST) && CapValid && (post_cnt == ONE_PTR)));
   end

   always_comb begin
      wr_entry        = '0;
      wr_entry.instr  = Instr;
      wr_entry.result = Result;
`ifdef ARM_TRACE_TIMESTAMP_EN
      wr_entry.stamp  = stamp_cnt;
`endif
   end

   arm_trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .AW    (PTR_W)
   ) u_ram (
      .CLK   (CLK),
      .we    (cap_wr),
      .waddr (waddr),
      .wdata (wr_entry),
      .raddr (rptr),
      .rdata (rd_entry)
   );

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state     <= IDLE;
         wptr      <= '0;
         rptr      <= '0;
         post_cnt  <= '0;
         count     <= '0;
         Triggered <= 1'b0;
         Done      <= 1'b0;
         RdValid   <= 1'b0;
         RdLast    <= 1'b0;
      end else begin
         if (cap_wr) begin
            wptr  <= wptr_nxt;
            count <= count_nxt;
         end else if (Arm) begin
            wptr  <= '0;
            count <= '0;
         end

         if (Arm) begin
            state     <= PRE;
            post_cnt  <= '0;
            Triggered <= 1'b0;
            Done      <= 1'b0;
            RdValid   <= 1'b0;
            RdLast    <= 1'b0;
         end else if (enter_done) begin
            // Oldest entry sits Count slots behind the post-write pointer.
            state   <= DONE;
            Done    <= 1'b1;
            RdValid <= 1'b1;
            RdLast  <= (count_nxt == ONE_CNT);
            rptr    <= wptr_nxt - count_nxt[PTR_W-1:0];
            if (trig_hit) begin
               Triggered <= 1'b1;
            end
         end else begin
            case (state)
               IDLE: ;
               PRE: begin
                  if (trig_hit) begin
                     Triggered <= 1'b1;
                     post_cnt  <= POST_LOAD;
                     state     <= POST;
                  end
               end
               POST: begin
                  if (CapValid) begin
                     post_cnt <= post_cnt - ONE_PTR;
                  end
               end
               DONE: begin
                  if (RdValid && RdReady) begin
                     if (RdLast) begin
                        RdValid <= 1'b0;
                        RdLast  <= 1'b0;
                     end else begin
                        rptr   <= rptr + ONE_PTR;
                        RdLast <= ((rptr + TWO_PTR) == wptr);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign Count    = count;
   assign RdInstr  = RdValid ? rd_entry.instr  : '0;
   assign RdResult = RdValid ? rd_entry.result : '0;
`ifdef ARM_TRACE_TIMESTAMP_EN
   assign RdStamp  = RdValid ? rd_entry.stamp  : '0;
`endif

endmodule

// File: doc/arm_trace_capture.md
Name: arm_trace_capture

Overview:
- Synthesizable trace capture unit for the single-cycle ARM core; replaces ad-hoc per-cycle console printing of Result/Instr.
- Snoops the core's Instr and Result every valid cycle into a circular buffer.
- Freezes the buffer on a masked instruction-match trigger after a programmable post-trigger count.
- Holds captured history for ordered readout over a valid/ready handshake, usable by benches and by on-chip debug logic.

Parameters:
- DATA_W, 32, width of each captured Instr and Result word
- DEPTH, 16, buffer entries; power of two, >= 4
- PTR_W, $clog2(DEPTH), pointer and count width (derived; do not override)
- POST_TRIG, 4, entries captured after the trigger entry; must be <= DEPTH-1

Ports:
- CLK  in  1  core clock, rising edge
- RESETn  in  1  asynchronous active-low reset
- Instr  in  DATA_W  instruction executing this cycle
- Result  in  DATA_W  ALU/writeback result this cycle
- CapValid  in  1  Instr/Result qualify this cycle (core not stalled)
- Arm  in  1  single-cycle pulse; starts a capture session
- TrigPat  in  DATA_W  instruction match pattern
- TrigMask  in  DATA_W  1 = compare bit; all-zero mask triggers on first valid cycle
- Triggered  out  1  trigger seen in current session
- Done  out  1  capture frozen, readout available
- RdReady  in  1  consumer accepts the current read beat
- RdValid  out  1  read beat valid
- RdInstr  out  DATA_W  captured Instr, oldest first
- RdResult  out  DATA_W  captured Result
- RdLast  out  1  final captured entry
- Count  out  PTR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Reset (async, RESETn=0):
  - State IDLE.
  - Triggered, Done, RdValid, RdLast = 0; Count = 0; Rd* data = 0.
  - Write pointer and post counter cleared.
  - Reset mid-capture or mid-readout discards the session.
- States: IDLE, PRE, POST, DONE.
- IDLE:
  - No writes.
  - Arm -> PRE; write pointer and Count cleared; Triggered and Done cleared.
- PRE:
  - Each CapValid cycle writes {Instr, Result} at the write pointer; pointer wraps modulo DEPTH.
  - Count saturates at DEPTH; the oldest entry is overwritten when full.
  - Trigger = CapValid && ((Instr ^ TrigPat) & TrigMask) == 0. The triggering entry is itself written.
  - On trigger: Triggered = 1 next cycle; post counter loaded with POST_TRIG.
  - If POST_TRIG = 0: -> DONE; otherwise -> POST.
- POST:
  - Each CapValid write decrements the post counter; at 0 -> DONE.
  - Non-valid cycles write nothing.
  - Further trigger matches are ignored.
- DONE:
  - No writes; Done = 1.
  - Read pointer starts at the oldest entry: (wptr - Count) mod DEPTH.
  - RdValid = 1 while entries remain.
  - RdInstr/RdResult are presented combinationally from the read pointer.
  - Beat transfers when RdValid && RdReady; read pointer advances and wraps.
  - RdLast = 1 on the entry at wptr-1.
  - After the last beat transfers: RdValid = 0, Done stays 1. State remains DONE until Arm.
- Arm in PRE/POST/DONE restarts the session in PRE; any pending readout is abandoned.
- Arm on the same cycle as a trigger: Arm wins; the entry is written as the first entry of the new session.
- Count = 0 in DONE is unreachable, because the trigger entry is always written. The bench asserts this.
- Count < DEPTH (trigger before the buffer fills): only Count entries are read.
- Latency:
  - Capture is 1 cycle, CapValid to storage.
  - Done asserts the cycle after the final post-trigger write.
  - First RdValid is the same cycle Done asserts.
- Storage is a reg array with no reset on data; pointers and flags are reset.

Optional Feature:
- Macro: ARM_TRACE_TIMESTAMP_EN.
- Enabled:
  - Free-running 16-bit cycle counter, reset to 0, wraps at 0xFFFF.
  - Counter value is stored with each entry.
  - Extra output RdStamp [15:0] aligned with RdInstr.
- Disabled: no counter, no RdStamp port, no timestamp storage.

Decomposition:
- Package arm_trace_pkg: state enum (IDLE=0, PRE=1, POST=2, DONE=3), default DATA_W/DEPTH constants, entry struct {instr, result[, stamp]}.
- One sub-module: arm_trace_ram, a DEPTH x entry-width register file with 1 write port and 1 asynchronous read port.
- Control FSM, pointers and counters stay in the top.

Test Plan:
- Reset mid-POST: assert RESETn=0 one cycle -> Done=0, Triggered=0, Count=0, RdValid=0; the next Arm restarts cleanly.
- DEPTH=16, POST_TRIG=4, 30 valid cycles with Instr=i; trigger on Instr=20 (mask 0xFFFFFFFF) -> Done after i=24; 16 beats read i=9..24; RdLast on 24.
- Trigger at cycle 3 (Instr=3), POST_TRIG=4 -> Count=8; reads 0..7 in order; RdLast on 7.
- CapValid toggling 1,0 during POST -> exactly 4 post entries stored; gaps not recorded.
- RdReady held 0 for 5 cycles mid-readout -> RdValid and data held stable; no beat lost or duplicated.
- Arm coincident with trigger in PRE -> session restarts; Triggered=0; Count=1 next cycle.
